// File: rtl/eth_tx_arb_pkg.sv
// eth_tx_arb_pkg: types, constants and the round-robin index helper
// shared by the TX frame arbiter and its picker.
`default_nettype none

package eth_tx_arb_pkg;

  typedef enum logic {IDLE = 1'b0, FWD = 1'b1} arb_state_t;

  localparam int FRAME_COUNT_WIDTH = 16;
  localparam int MAX_PORTS         = 8;
  localparam int IDX_W             = 3;

  // Advance a port index by one, wrapping after max_idx.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                               input logic [IDX_W-1:0] max_idx);
    return (idx == max_idx) ? '0 : idx + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; scans i_last_idx+1, +2, ...
// modulo NUM_PORTS and returns the first requesting index.
`default_nettype none

module rr_pick
  import eth_tx_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_last_idx,
  output logic                 o_found,
  output logic [IDX_W-1:0]     o_pick_idx
);

  logic [MAX_PORTS-1:0] w_req_ext;
  logic [IDX_W-1:0]     w_cand;

  assign w_req_ext = MAX_PORTS'(i_req);

  always_comb begin
    o_found    = 1'b0;
    o_pick_idx = '0;
    w_cand     = i_last_idx;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_cand = rr_next(w_cand, IDX_W'(NUM_PORTS - 1));
      if (!o_found && w_req_ext[w_cand]) begin
        o_found    = 1'b1;
        o_pick_idx = w_cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/eth_tx_frame_arbiter.sv
// eth_tx_frame_arbiter: frame-granular round-robin mux of NUM_PORTS AXI4-Stream
// sources onto the MAC TX input. Optional counters: ETH_TX_ARB_FRAME_COUNT_EN.
`default_nettype none

module eth_tx_frame_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                            clock,
  input  logic                            aresetn,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS-1:0]            s_tvalid,
  input  logic [NUM_PORTS-1:0]            s_tlast,
  output logic [NUM_PORTS-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            m_tlast,
  output logic [NUM_PORTS-1:0]            grant,
  output logic                            busy
`ifdef ETH_TX_ARB_FRAME_COUNT_EN
  ,
  output logic [NUM_PORTS*FRAME_COUNT_WIDTH-1:0] frame_count
`endif
);

  arb_state_t           r_state;
  logic [IDX_W-1:0]     r_grant_idx;
  logic [IDX_W-1:0]     r_last_idx;
  logic [NUM_PORTS-1:0] r_grant;
  logic                 r_busy;

  logic                  w_found;
  logic [IDX_W-1:0]      w_pick_idx;
  logic                  w_fwd;
  logic [DATA_WIDTH-1:0] w_m_tdata;
  logic                  w_m_tvalid;
  logic                  w_m_tlast;
  logic [NUM_PORTS-1:0]  w_s_tready;
  logic                  w_eof;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_pick (
    .i_req      (s_tvalid),
    .i_last_idx (r_last_idx),
    .o_found    (w_found),
    .o_pick_idx (w_pick_idx)
  );

  assign w_fwd = (r_state == FWD);

  // Forwarding path is purely combinational; everything is gated by FWD so the
  // outputs fall to zero as soon as reset forces the state back to IDLE.
  always_comb begin
    w_m_tdata  = '0;
    w_m_tvalid = 1'b0;
    w_m_tlast  = 1'b0;
    w_s_tready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_fwd && (r_grant_idx == IDX_W'(i))) begin
        w_m_tdata     = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_m_tvalid    = s_tvalid[i];
        w_m_tlast     = s_tlast[i];
        w_s_tready[i] = m_tready;
      end
    end
  end

  assign w_eof = w_m_tvalid & m_tready & w_m_tlast;

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_grant_idx <= '0;
      r_last_idx  <= IDX_W'(NUM_PORTS - 1);
      r_grant     <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant_idx <= w_pick_idx;
            r_grant     <= NUM_PORTS'(1) << w_pick_idx;
            r_busy      <= 1'b1;
            r_state     <= FWD;
          end
        end
        FWD: begin
          if (w_eof) begin
            r_last_idx <= r_grant_idx;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_tdata  = w_m_tdata;
  assign m_tvalid = w_m_tvalid;
  assign m_tlast  = w_m_tlast;
  assign s_tready = w_s_tready;
  assign grant    = r_grant;
  assign busy     = r_busy;

`ifdef ETH_TX_ARB_FRAME_COUNT_EN
  generate
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_frame_count
      logic [FRAME_COUNT_WIDTH-1:0] r_cnt;
      always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
          r_cnt <= '0;
        end else if (w_eof && (r_grant_idx == IDX_W'(g))) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      assign frame_count[g*FRAME_COUNT_WIDTH +: FRAME_COUNT_WIDTH] = r_cnt;
    end
  endgenerate
`endif

endmodule

`default_nettype wire
